// File: rtl/seq_signed_multiplier32.sv
// Sequential 32x32 signed multiply-accumulate (radix-2 Booth, one bit per clock): product = M*Q + sext(addend).
// 32 RUN cycles after the accepting edge, then a one-cycle done pulse; start is ignored while busy.
module seq_signed_multiplier32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic [31:0] addend,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic [31:0] addend_q, addend_d;
  logic [32:0] a_q, a_d;
  logic        qm1_q, qm1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] product_q, product_d;

  logic [32:0] m_ext;
  logic [32:0] sum;
  logic [32:0] a_sh;
  logic [31:0] q_sh;
  logic [63:0] final_sum;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    addend_d  = addend_q;
    a_d       = a_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    // 33-bit accumulator keeps -(-2^31) representable
    m_ext = {m_q[31], m_q};
    sum   = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase

    a_sh      = {sum[32], sum[32:1]};
    q_sh      = {sum[0], q_q[31:1]};
    final_sum = {a_sh[31:0], q_sh} + {{32{addend_q[31]}}, addend_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d      = multiplicand;
          q_d      = multiplier;
          addend_d = addend;
          a_d      = 33'd0;
          qm1_d    = 1'b0;
          cnt_d    = 5'd0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          product_d = final_sum;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= 32'd0;
      q_q       <= 32'd0;
      addend_q  <= 32'd0;
      a_q       <= 33'd0;
      qm1_q     <= 1'b0;
      cnt_q     <= 5'd0;
      product_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      addend_q  <= addend_d;
      a_q       <= a_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
